// File: rtl/ram_dma.sv
// ram_dma: block COPY (RAM to RAM, ascending) and FILL engine driving a single-port RAM.
// A COPY word takes a read cycle then a write cycle; FILL writes one word per cycle.
module ram_dma #(
   parameter int AW  = 8,
   parameter int DW  = 8,
   parameter int RDW = 16
) (
   input  logic           clk,
   input  logic           clr,
   input  logic           start,
   input  logic           mode,
   input  logic [AW-1:0]  src,
   input  logic [AW-1:0]  dst,
   input  logic [AW-1:0]  len,
   input  logic [DW-1:0]  fill_val,
   output logic           busy,
   output logic           done,
   output logic           trunc,
   output logic           ram_rw,
   output logic [AW-1:0]  ram_adrs,
   output logic [DW-1:0]  ram_din,
   input  logic [RDW-1:0] ram_dout
);
   typedef enum logic [2:0] {IDLE, RD, WR, FILL, DONE} state_t;
   state_t state, state_nx;
   logic [AW-1:0] src_ptr, dst_ptr, cnt;
   logic [DW-1:0] dat;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state   <= IDLE;
         src_ptr <= '0;
         dst_ptr <= '0;
         cnt     <= '0;
         dat     <= '0;
         trunc   <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (start) begin
               src_ptr <= src;
               dst_ptr <= dst;
               cnt     <= len;
               dat     <= fill_val;
               trunc   <= 1'b0;
            end
            RD: begin
               dat     <= ram_dout[DW-1:0];
               trunc   <= trunc | (|ram_dout[RDW-1:DW]);
               src_ptr <= src_ptr + 1'b1;
            end
            WR, FILL: begin
               dst_ptr <= dst_ptr + 1'b1;
               cnt     <= cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      ram_rw   = 1'b0;
      ram_adrs = '0;
      ram_din  = '0;
      case (state)
         IDLE: if (start) state_nx = (len == '0) ? DONE : (mode ? FILL : RD);
         RD: begin
            busy     = 1'b1;
            ram_adrs = src_ptr;
            state_nx = WR;
         end
         WR: begin
            busy     = 1'b1;
            ram_rw   = 1'b1;
            ram_adrs = dst_ptr;
            ram_din  = dat;
            state_nx = (cnt == AW'(1)) ? DONE : RD;
         end
         FILL: begin
            busy     = 1'b1;
            ram_rw   = 1'b1;
            ram_adrs = dst_ptr;
            ram_din  = dat;
            state_nx = (cnt == AW'(1)) ? DONE : FILL;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
endmodule

// File: tb/tb_ram_dma.sv
// tb_ram_dma: randomized and directed jobs checked cycle by cycle against a
// job-level model that expands each accepted request into its expected bus cycles.
module tb_ram_dma;
   logic clk = 1'b0, clr = 1'b0, start = 1'b0, mode = 1'b0;
   logic [7:0] src = '0, dst = '0, len = '0, fill_val = '0;
   logic busy, done, trunc, ram_rw;
   logic [7:0] ram_adrs, ram_din;
   logic [15:0] ram_dout;
   logic [15:0] mem [256];
   logic [15:0] ref_mem [256];
   logic poke_en = 1'b0;
   logic [7:0] poke_a = '0;
   logic [15:0] poke_v = '0;
   int n_chk = 0, n_fail = 0;

   typedef struct {
      bit busy, done, rw, chk_adrs, trunc;
      logic [7:0] adrs, din;
   } exp_t;
   exp_t q[$];
   bit last_trunc = 1'b0;

   always #5 clk = ~clk;

   ram_dma dut (
      .clk(clk), .clr(clr), .start(start), .mode(mode), .src(src), .dst(dst),
      .len(len), .fill_val(fill_val), .busy(busy), .done(done), .trunc(trunc),
      .ram_rw(ram_rw), .ram_adrs(ram_adrs), .ram_din(ram_din), .ram_dout(ram_dout)
   );

   assign ram_dout = mem[ram_adrs];

   always @(posedge clk) begin
      if (ram_rw) mem[ram_adrs] <= {8'h00, ram_din};
      else if (poke_en) mem[poke_a] <= poke_v;
   end

   function automatic exp_t mk(bit b, bit dn, bit rw, bit ca, bit t, logic [7:0] a, logic [7:0] d);
      exp_t e;
      e.busy = b; e.done = dn; e.rw = rw; e.chk_adrs = ca; e.trunc = t; e.adrs = a; e.din = d;
      return e;
   endfunction

   // Expand an accepted request into its cycle sequence, simulating the copy on a scratch RAM
   function automatic void build();
      logic [15:0] s_mem [256];
      logic [7:0] a, b, v;
      bit t;
      s_mem = ref_mem;
      t = 1'b0;
      for (int i = 0; i < int'(len); i++) begin
         a = src + 8'(i);
         b = dst + 8'(i);
         if (mode) q.push_back(mk(1, 0, 1, 1, 0, b, fill_val));
         else begin
            q.push_back(mk(1, 0, 0, 1, t, a, 8'h00));
            t = t | (s_mem[a][15:8] != 8'h00);
            v = s_mem[a][7:0];
            s_mem[b] = {8'h00, v};
            q.push_back(mk(1, 0, 1, 1, t, b, v));
         end
      end
      q.push_back(mk(0, 1, 0, 0, t, 8'h00, 8'h00));
   endfunction

   always @(posedge clk) begin
      exp_t e;
      bit was_idle;
      was_idle = (q.size() == 0);
      if (!was_idle) begin
         e = q.pop_front();
         if (e.rw) ref_mem[e.adrs] = {8'h00, e.din};
         last_trunc = e.trunc;
      end
      if (was_idle && clr && start) build();
   end

   always @(negedge clr) begin
      q.delete();
      last_trunc = 1'b0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) if (clr) begin
      exp_t e;
      e = (q.size() != 0) ? q[0] : mk(0, 0, 0, 1, last_trunc, 8'h00, 8'h00);
      chk("busy", 32'(busy), 32'(e.busy));
      chk("done", 32'(done), 32'(e.done));
      chk("ram_rw", 32'(ram_rw), 32'(e.rw));
      chk("trunc", 32'(trunc), 32'(e.trunc));
      if (e.chk_adrs) chk("ram_adrs", 32'(ram_adrs), 32'(e.adrs));
      if (e.rw) chk("ram_din", 32'(ram_din), 32'(e.din));
   end

   task automatic poke(input logic [7:0] a, input logic [15:0] v);
      poke_a = a; poke_v = v; poke_en = 1'b1;
      ref_mem[a] = v;
      @(posedge clk);
      #1 poke_en = 1'b0;
   endtask

   task automatic mem_cmp(input string name);
      int bad;
      bad = -1;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i] && bad < 0) bad = i;
      n_chk++;
      if (bad >= 0) begin
         n_fail++;
         $display("FAIL %s: mem[%0h]=%0h expected %0h", name, bad, mem[bad], ref_mem[bad]);
      end
   endtask

   task automatic run_job(input bit m, input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                          input logic [7:0] f, input int restart,
                          output int done_cyc, output int busy_n, output int wr_n, output int done_n);
      int bound;
      @(posedge clk);
      #2;
      mode = m; src = s; dst = d; len = l; fill_val = f; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      mode = 1'($urandom); src = 8'($urandom); dst = 8'($urandom);
      len = 8'($urandom); fill_val = 8'($urandom);
      done_cyc = 0; busy_n = 0; wr_n = 0; done_n = 0;
      bound = 2 * int'(l) + 4;
      for (int k = 1; k <= bound + 3; k++) begin
         @(negedge clk);
         if (busy) busy_n++;
         if (ram_rw) wr_n++;
         if (done) begin
            done_n++;
            if (done_cyc == 0) done_cyc = k;
         end
         start = (k == restart);
         if (done_cyc != 0 && k >= done_cyc + 3) break;
      end
      start = 1'b0;
      if (done_cyc == 0) chk("done_timeout", 0, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int dc, bn, wn, dn, r, exp_dc;
      bit m;
      logic [7:0] l;
      #2;
      chk("reset_outputs", {busy, done, trunc, ram_rw}, 0);
      chk("reset_adrs_din", {ram_adrs, ram_din}, 0);
      for (int i = 0; i < 256; i++) poke(8'(i), 16'($urandom));
      @(negedge clk);
      clr = 1'b1;

      // abort a COPY at cycle 5 (the third read): only two words may land
      for (int i = 0; i < 8; i++) poke(8'h10 + 8'(i), 16'h0030 + 16'(i));
      poke(8'h80, 16'hDEAD); poke(8'h81, 16'hDEAD); poke(8'h82, 16'hBEEF);
      @(posedge clk);
      #2;
      mode = 1'b0; src = 8'h10; dst = 8'h80; len = 8'd8; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #2 clr = 1'b0;
      #1;
      chk("abort_rw", 32'(ram_rw), 0);
      chk("abort_busy_done", {busy, done}, 0);
      repeat (2) @(negedge clk);
      clr = 1'b1;
      repeat (2) @(negedge clk);
      chk("abort_m80", mem[8'h80], 16'h0030);
      chk("abort_m81", mem[8'h81], 16'h0031);
      chk("abort_m82", mem[8'h82], 16'hBEEF);
      chk("abort_idle", 32'(busy), 0);
      mem_cmp("abort_mem");

      poke(8'h24, 16'h1234);
      run_job(1, 8'h00, 8'h20, 8'd4, 8'hA5, 0, dc, bn, wn, dn);
      chk("fill_done_cyc", dc, 5);
      chk("fill_busy_n", bn, 4);
      chk("fill_wr_n", wn, 4);
      for (int i = 0; i < 4; i++) chk("fill_word", mem[8'h20 + 8'(i)], 16'h00A5);
      chk("fill_untouched", mem[8'h24], 16'h1234);
      mem_cmp("fill_mem");

      poke(8'h10, 16'h0011); poke(8'h11, 16'h0122); poke(8'h12, 16'h0033);
      run_job(0, 8'h10, 8'h40, 8'd3, 8'h00, 0, dc, bn, wn, dn);
      chk("copy_done_cyc", dc, 7);
      chk("copy_busy_n", bn, 6);
      chk("copy_trunc", 32'(trunc), 1);
      chk("copy_m40", mem[8'h40], 16'h0011);
      chk("copy_m41", mem[8'h41], 16'h0022);
      chk("copy_m42", mem[8'h42], 16'h0033);
      mem_cmp("copy_mem");

      run_job(1, 8'h00, 8'hFE, 8'd3, 8'h5C, 0, dc, bn, wn, dn);
      chk("wrap_done_cyc", dc, 4);
      chk("wrap_mFE", mem[8'hFE], 16'h005C);
      chk("wrap_mFF", mem[8'hFF], 16'h005C);
      chk("wrap_m00", mem[8'h00], 16'h005C);
      run_job(0, 8'h33, 8'h44, 8'd0, 8'h00, 0, dc, bn, wn, dn);
      chk("noop_done_cyc", dc, 1);
      chk("noop_wr_n", wn, 0);
      chk("noop_busy_n", bn, 0);
      mem_cmp("wrap_mem");

      for (int i = 0; i < 4; i++) poke(8'(i), 16'(i + 1));
      run_job(0, 8'h00, 8'h01, 8'd3, 8'h00, 3, dc, bn, wn, dn);
      chk("ovl_done_cyc", dc, 7);
      chk("ovl_done_n", dn, 1);
      chk("ovl_wr_n", wn, 3);
      for (int i = 0; i < 4; i++) chk("ovl_word", mem[8'(i)], 16'h0001);
      mem_cmp("ovl_mem");

      for (int j = 0; j < 30; j++) begin
         m = 1'($urandom);
         l = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
         r = (l == 0 || $urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, m ? int'(l) : 2 * int'(l)));
         run_job(m, 8'($urandom), 8'($urandom), l, 8'($urandom), r, dc, bn, wn, dn);
         exp_dc = (l == 0) ? 1 : (m ? int'(l) + 1 : 2 * int'(l) + 1);
         chk("rnd_done_cyc", dc, exp_dc);
         chk("rnd_done_n", dn, 1);
         chk("rnd_wr_n", wn, int'(l));
         mem_cmp("rnd_mem");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
